exec_stage_alu: RTL and testbench
=================================

Name: exec_stage_alu

Overview:
- Execute-stage datapath core of the 5-stage MIPS pipeline, sitting between the D/E and E/M pipeline registers.
- Decodes the E-stage instruction into ALU, mul/div and output-select controls.
- Applies RS/RT forwarding, computes the ALU result and overflow flags, and registers results into the E/M pipeline register.
- The HI/LO multiply/divide unit is external: it is driven by this block's MD controls and its HI/LO outputs feed back in.

Parameters:
- none (fixed 32-bit MIPS datapath)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  reset, synchronous, active-high
- Flush  in  1  exception flush; clears the E/M register like Reset
- IRE  in  32  E-stage instruction
- PC4E  in  32  E-stage PC+4
- RSE  in  32  rs value from D/E register
- RTE  in  32  rt value from D/E register
- EXTE  in  32  extended immediate (already zero/sign-extended)
- Shift  in  5  shamt for constant shifts
- Fwd_RS_sel  in  2  rs forward select
- Fwd_RT_sel  in  2  rt forward select
- AO_M  in  32  M-stage ALU result
- PC4_fw_M  in  32  M-stage link value
- WD_W  in  32  W-stage register write data
- HI  in  32  HI from external mul/div unit
- LO  in  32  LO from external mul/div unit
- SrcA  out  32  forwarded rs (operand to mul/div)
- SrcB  out  32  ALU operand B (operand to mul/div)
- MD_op  out  2  0=mult, 1=multu, 2=div, 3=divu
- MD_start  out  1  high for mult/multu/div/divu
- MD_we  out  2  1=mthi, 2=mtlo, 0=none
- OvArith  out  1  signed overflow of add/sub/addi
- OvMem  out  1  signed overflow of load/store address add
- IRM, PC4M, AOM, RTM  out  32 each  E/M register outputs

Behaviour:
- Forward mux (each of RS, RT): sel 0 = RSE/RTE, 1 = AO_M, 2 = WD_W, 3 = PC4_fw_M.
- SrcA = forwarded rs. SrcB = EXTE if ALUsrc else forwarded rt. All combinational.
- ALUsrc = 1 for: addi, addiu, andi, ori, xori, lui, slti, sltiu, lb, lbu, lh, lhu, lw, sb, sh, sw.
- ALU ops:
  - ADD: A+B (add, addu, addi, addiu, loads/stores, default)
  - SUB: A-B (sub, subu)
  - AND, OR, XOR, NOR
  - SLT: signed compare, result 1/0 (slt, slti)
  - SLTU: unsigned compare (sltu, sltiu)
  - LUI: B<<16
  - Constant shifts sll/srl/sra use Shift.
  - Variable shifts sllv/srlv/srav use A[4:0] and shift B.
- Output select: mfhi gives HI, mflo gives LO, else ALU result.
- OvArith = 33-bit signed overflow (bit32 != bit31 of sign-extended sum/difference), gated to add, sub, addi only. addu, subu, addiu never flag.
- OvMem = same overflow test on A+EXTE, gated to load/store opcodes.
- Unrecognised instructions, including nop 0x00000000: ADD with B=rt, no flags, no MD activity.
- E/M register, every rising Clk:
  - If Reset or Flush: IRM=0, PC4M=0, AOM=0, RTM=0.
  - Else: IRM<=IRE, PC4M<=PC4E, AOM<=selected result, RTM<=forwarded rt.
  - Reset and Flush have equal priority over load.
- Latency: 1 cycle from E inputs to E/M outputs.
- Initial/power-up value of all registers: 0.

Decomposition:
- Shared package mips_defs_pkg holds: opcode/funct constants, ALUop enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, LUI, SLL, SRL, SRA, SLLV, SRLV, SRAV), forward-select constants, MD_op/MD_we constants.
- One sub-module exec_alu (pure combinational ALU plus overflow). Decode and forwarding stay in the top.

Test Plan:
- addu, rs=5, rt=7, sel 0/0 -> AOM=12 next edge, OvArith=0, IRM=IRE.
- add, RSE=0x7FFFFFFF, RTE=1 -> OvArith=1. Same operands with addu -> OvArith=0, AOM=0x80000000.
- Fwd_RS_sel=1 (AO_M=100), Fwd_RT_sel=2 (WD_W=3), subu -> AOM=97 and RTM=3. With Fwd_RS_sel=3, PC4_fw_M=0x3008 -> SrcA=0x3008.
- Shifts: sra with Shift=4, RTE=0x80000000 -> 0xF8000000. srlv with rs=36, rt=0xF0 -> 0x0F. lui with EXTE=0x1234 -> 0x12340000.
- slt with rs=-1, rt=1 -> 1. sltu with the same operands -> 0. lw with rs=0x7FFFFFF0, EXTE=0x20 -> OvMem=1.
- mult -> MD_start=1, MD_op=0. mthi -> MD_we=1. mflo with LO=0xABCD -> AOM=0xABCD. Reset or Flush asserted at the edge -> all E/M outputs 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS execute-stage definitions: opcodes, functs, ALU ops, forward and mul/div encodings.
package mips_defs_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV
    } alu_op_e;

    typedef enum logic [1:0] {
        OUT_ALU, OUT_HI, OUT_LO
    } out_sel_e;

    localparam logic [1:0] FWD_REG  = 2'd0;
    localparam logic [1:0] FWD_AO_M = 2'd1;
    localparam logic [1:0] FWD_WD_W = 2'd2;
    localparam logic [1:0] FWD_PC4M = 2'd3;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [1:0] MD_WE_NONE = 2'd0;
    localparam logic [1:0] MD_WE_HI   = 2'd1;
    localparam logic [1:0] MD_WE_LO   = 2'd2;

    // Bypass mux shared by the rs and rt paths
    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] ao_m,
        input logic [DATA_W-1:0] wd_w,
        input logic [DATA_W-1:0] pc4_m
    );
        logic [DATA_W-1:0] r;
        case (sel)
            FWD_AO_M: r = ao_m;
            FWD_WD_W: r = wd_w;
            FWD_PC4M: r = pc4_m;
            default:  r = reg_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU with signed-overflow flags for add and subtract.
module exec_alu
    import mips_defs_pkg::*;
(
    input  alu_op_e             alu_op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic [DATA_W-1:0]   result,
    output logic                ov_add,
    output logic                ov_sub
);

    logic [DATA_W:0]      sum_ext;
    logic [DATA_W:0]      diff_ext;
    logic [SHAMT_W-1:0]   var_sh;

    // Sign-extended 33-bit forms expose overflow as bit32 != bit31
    assign sum_ext  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign diff_ext = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    assign ov_add   = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    assign ov_sub   = diff_ext[DATA_W] ^ diff_ext[DATA_W-1];
    assign var_sh   = a[SHAMT_W-1:0];

    always_comb begin
        result = sum_ext[DATA_W-1:0];
        case (alu_op)
            ALU_ADD:  result = sum_ext[DATA_W-1:0];
            ALU_SUB:  result = diff_ext[DATA_W-1:0];
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = DATA_W'($signed(a) < $signed(b));
            ALU_SLTU: result = DATA_W'(a < b);
            ALU_LUI:  result = {b[15:0], 16'h0000};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = DATA_W'($signed(b) >>> shamt);
            ALU_SLLV: result = b << var_sh;
            ALU_SRLV: result = b >> var_sh;
            ALU_SRAV: result = DATA_W'($signed(b) >>> var_sh);
            default:  result = sum_ext[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/exec_stage_alu.sv
// MIPS execute stage: decode, rs/rt bypass, ALU, mul/div control and the E/M pipeline register.
module exec_stage_alu
    import mips_defs_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Flush,
    input  logic [DATA_W-1:0]   IRE,
    input  logic [DATA_W-1:0]   PC4E,
    input  logic [DATA_W-1:0]   RSE,
    input  logic [DATA_W-1:0]   RTE,
    input  logic [DATA_W-1:0]   EXTE,
    input  logic [SHAMT_W-1:0]  Shift,
    input  logic [1:0]          Fwd_RS_sel,
    input  logic [1:0]          Fwd_RT_sel,
    input  logic [DATA_W-1:0]   AO_M,
    input  logic [DATA_W-1:0]   PC4_fw_M,
    input  logic [DATA_W-1:0]   WD_W,
    input  logic [DATA_W-1:0]   HI,
    input  logic [DATA_W-1:0]   LO,
    output logic [DATA_W-1:0]   SrcA,
    output logic [DATA_W-1:0]   SrcB,
    output logic [1:0]          MD_op,
    output logic                MD_start,
    output logic [1:0]          MD_we,
    output logic                OvArith,
    output logic                OvMem,
    output logic [DATA_W-1:0]   IRM,
    output logic [DATA_W-1:0]   PC4M,
    output logic [DATA_W-1:0]   AOM,
    output logic [DATA_W-1:0]   RTM
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    alu_op_e           alu_op;
    out_sel_e          out_sel;
    logic              alu_src;
    logic              ov_add_en;
    logic              ov_sub_en;
    logic              ov_mem_en;
    logic              md_start;
    logic [1:0]        md_op;
    logic [1:0]        md_we;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] stage_result;
    logic              ov_add;
    logic              ov_sub;

    assign opcode = IRE[31:26];
    assign funct  = IRE[5:0];

    // Instruction decode; anything unlisted falls through to a plain rs+rt add
    always_comb begin
        alu_op    = ALU_ADD;
        out_sel   = OUT_ALU;
        alu_src   = 1'b0;
        ov_add_en = 1'b0;
        ov_sub_en = 1'b0;
        ov_mem_en = 1'b0;
        md_start  = 1'b0;
        md_op     = MD_MULT;
        md_we     = MD_WE_NONE;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:   begin alu_op = ALU_ADD; ov_add_en = 1'b1; end
                FN_ADDU:  alu_op = ALU_ADD;
                FN_SUB:   begin alu_op = ALU_SUB; ov_sub_en = 1'b1; end
                FN_SUBU:  alu_op = ALU_SUB;
                FN_AND:   alu_op = ALU_AND;
                FN_OR:    alu_op = ALU_OR;
                FN_XOR:   alu_op = ALU_XOR;
                FN_NOR:   alu_op = ALU_NOR;
                FN_SLT:   alu_op = ALU_SLT;
                FN_SLTU:  alu_op = ALU_SLTU;
                // The all-zero word is a nop, not a real sll
                FN_SLL:   if (IRE != '0) alu_op = ALU_SLL;
                FN_SRL:   alu_op = ALU_SRL;
                FN_SRA:   alu_op = ALU_SRA;
                FN_SLLV:  alu_op = ALU_SLLV;
                FN_SRLV:  alu_op = ALU_SRLV;
                FN_SRAV:  alu_op = ALU_SRAV;
                FN_MFHI:  out_sel = OUT_HI;
                FN_MFLO:  out_sel = OUT_LO;
                FN_MTHI:  md_we = MD_WE_HI;
                FN_MTLO:  md_we = MD_WE_LO;
                FN_MULT:  begin md_start = 1'b1; md_op = MD_MULT;  end
                FN_MULTU: begin md_start = 1'b1; md_op = MD_MULTU; end
                FN_DIV:   begin md_start = 1'b1; md_op = MD_DIV;   end
                FN_DIVU:  begin md_start = 1'b1; md_op = MD_DIVU;  end
                default:  alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ADDI:  begin alu_op = ALU_ADD; alu_src = 1'b1; ov_add_en = 1'b1; end
                OP_ADDIU: begin alu_op = ALU_ADD; alu_src = 1'b1; end
                OP_SLTI:  begin alu_op = ALU_SLT; alu_src = 1'b1; end
                OP_SLTIU: begin alu_op = ALU_SLTU; alu_src = 1'b1; end
                OP_ANDI:  begin alu_op = ALU_AND; alu_src = 1'b1; end
                OP_ORI:   begin alu_op = ALU_OR; alu_src = 1'b1; end
                OP_XORI:  begin alu_op = ALU_XOR; alu_src = 1'b1; end
                OP_LUI:   begin alu_op = ALU_LUI; alu_src = 1'b1; end
                OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: begin
                    alu_op    = ALU_ADD;
                    alu_src   = 1'b1;
                    ov_mem_en = 1'b1;
                end
                default:  alu_op = ALU_ADD;
            endcase
        end
    end

    assign rs_fwd = fwd_mux(Fwd_RS_sel, RSE, AO_M, WD_W, PC4_fw_M);
    assign rt_fwd = fwd_mux(Fwd_RT_sel, RTE, AO_M, WD_W, PC4_fw_M);

    assign SrcA = rs_fwd;
    assign SrcB = alu_src ? EXTE : rt_fwd;

    exec_alu u_alu (
        .alu_op (alu_op),
        .a      (SrcA),
        .b      (SrcB),
        .shamt  (Shift),
        .result (alu_result),
        .ov_add (ov_add),
        .ov_sub (ov_sub)
    );

    // Load/store addresses always use EXTE as B, so the add flag doubles as the address check
    assign OvArith  = (ov_add_en & ov_add) | (ov_sub_en & ov_sub);
    assign OvMem    = ov_mem_en & ov_add;
    assign MD_start = md_start;
    assign MD_op    = md_op;
    assign MD_we    = md_we;

    always_comb begin
        stage_result = alu_result;
        case (out_sel)
            OUT_HI:  stage_result = HI;
            OUT_LO:  stage_result = LO;
            default: stage_result = alu_result;
        endcase
    end

    // E/M pipeline register
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            IRM  <= '0;
            PC4M <= '0;
            AOM  <= '0;
            RTM  <= '0;
        end else begin
            IRM  <= IRE;
            PC4M <= PC4E;
            AOM  <= stage_result;
            RTM  <= rt_fwd;
        end
    end

endmodule

// File: tb/tb_exec_stage_alu.sv
// Directed vector bench for exec_stage_alu: decode, bypass, ALU, flags, mul/div controls, reset/flush.
module tb_exec_stage_alu;

    logic        Clk = 1'b0;
    logic        Reset, Flush;
    logic [31:0] IRE, PC4E, RSE, RTE, EXTE;
    logic [4:0]  Shift;
    logic [1:0]  Fwd_RS_sel, Fwd_RT_sel;
    logic [31:0] AO_M, PC4_fw_M, WD_W, HI, LO;
    logic [31:0] SrcA, SrcB;
    logic [1:0]  MD_op, MD_we;
    logic        MD_start, OvArith, OvMem;
    logic [31:0] IRM, PC4M, AOM, RTM;

    int n_tests = 0;
    int n_fail  = 0;

    exec_stage_alu dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .IRE(IRE), .PC4E(PC4E),
        .RSE(RSE), .RTE(RTE), .EXTE(EXTE), .Shift(Shift),
        .Fwd_RS_sel(Fwd_RS_sel), .Fwd_RT_sel(Fwd_RT_sel),
        .AO_M(AO_M), .PC4_fw_M(PC4_fw_M), .WD_W(WD_W), .HI(HI), .LO(LO),
        .SrcA(SrcA), .SrcB(SrcB), .MD_op(MD_op), .MD_start(MD_start), .MD_we(MD_we),
        .OvArith(OvArith), .OvMem(OvMem), .IRM(IRM), .PC4M(PC4M), .AOM(AOM), .RTM(RTM)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] ir, rse, rte, exte;
        logic [4:0]  sh;
        logic [1:0]  frs, frt;
        logic [31:0] aom, srca, srcb, rtm;
        logic        ova, ovm, mds;
        logic [1:0]  mdop, mdwe;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rt_ir(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ir(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h0};
    endfunction

    function automatic vec_t mk(
        input string n, input logic [31:0] ir, rse, rte, exte, input logic [4:0] sh,
        input logic [1:0] frs, frt, input logic [31:0] aom, srca, srcb, rtm,
        input logic ova, ovm, mds, input logic [1:0] mdop, mdwe);
        vec_t v;
        v.name = n; v.ir = ir; v.rse = rse; v.rte = rte; v.exte = exte; v.sh = sh;
        v.frs = frs; v.frt = frt; v.aom = aom; v.srca = srca; v.srcb = srcb; v.rtm = rtm;
        v.ova = ova; v.ovm = ovm; v.mds = mds; v.mdop = mdop; v.mdwe = mdwe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_em_zero(input string tag);
        check({tag, ".IRM"},  IRM,  32'h0);
        check({tag, ".PC4M"}, PC4M, 32'h0);
        check({tag, ".AOM"},  AOM,  32'h0);
        check({tag, ".RTM"},  RTM,  32'h0);
    endtask

    initial begin
        // Fixed bypass sources for every vector
        AO_M = 32'd100; WD_W = 32'd3; PC4_fw_M = 32'h3008; HI = 32'h5555; LO = 32'hABCD;

        //          name      ir               rse          rte          exte         sh frs frt aom          srca         srcb         rtm         ova ovm mds op  we
        vecs.push_back(mk("addu",  rt_ir(6'h21), 32'd5,       32'd7,       32'h0,       0, 0, 0, 32'd12,      32'd5,       32'd7,       32'd7,       0, 0, 0, 0, 0));
        vecs.push_back(mk("add_ov",rt_ir(6'h20), 32'h7FFFFFFF,32'd1,       32'h0,       0, 0, 0, 32'h80000000,32'h7FFFFFFF,32'd1,       32'd1,       1, 0, 0, 0, 0));
        vecs.push_back(mk("addu_w",rt_ir(6'h21), 32'h7FFFFFFF,32'd1,       32'h0,       0, 0, 0, 32'h80000000,32'h7FFFFFFF,32'd1,       32'd1,       0, 0, 0, 0, 0));
        vecs.push_back(mk("subu_f",rt_ir(6'h23), 32'hAAAA,    32'hBBBB,    32'h0,       0, 1, 2, 32'd97,      32'd100,     32'd3,       32'd3,       0, 0, 0, 0, 0));
        vecs.push_back(mk("fwd_pc",rt_ir(6'h21), 32'h0,       32'h0,       32'h0,       0, 3, 0, 32'h3008,    32'h3008,    32'h0,       32'h0,       0, 0, 0, 0, 0));
        vecs.push_back(mk("sra",   rt_ir(6'h03), 32'h0,       32'h80000000,32'h0,       4, 0, 0, 32'hF8000000,32'h0,       32'h80000000,32'h80000000,0, 0, 0, 0, 0));
        vecs.push_back(mk("srlv",  rt_ir(6'h06), 32'd36,      32'hF0,      32'h0,       0, 0, 0, 32'h0F,      32'd36,      32'hF0,      32'hF0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("lui",   i_ir(6'h0F),  32'h0,       32'h99,      32'h1234,    0, 0, 0, 32'h12340000,32'h0,       32'h1234,    32'h99,      0, 0, 0, 0, 0));
        vecs.push_back(mk("slt",   rt_ir(6'h2A), 32'hFFFFFFFF,32'd1,       32'h0,       0, 0, 0, 32'd1,       32'hFFFFFFFF,32'd1,       32'd1,       0, 0, 0, 0, 0));
        vecs.push_back(mk("sltu",  rt_ir(6'h2B), 32'hFFFFFFFF,32'd1,       32'h0,       0, 0, 0, 32'd0,       32'hFFFFFFFF,32'd1,       32'd1,       0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_ov", i_ir(6'h23),  32'h7FFFFFF0,32'h0,       32'h20,      0, 0, 0, 32'h80000010,32'h7FFFFFF0,32'h20,      32'h0,       0, 1, 0, 0, 0));
        vecs.push_back(mk("mult",  rt_ir(6'h18), 32'd3,       32'd4,       32'h0,       0, 0, 0, 32'd7,       32'd3,       32'd4,       32'd4,       0, 0, 1, 0, 0));
        vecs.push_back(mk("mthi",  rt_ir(6'h11), 32'h42,      32'h0,       32'h0,       0, 0, 0, 32'h42,      32'h42,      32'h0,       32'h0,       0, 0, 0, 0, 1));
        vecs.push_back(mk("mflo",  rt_ir(6'h12), 32'd1,       32'd2,       32'h0,       0, 0, 0, 32'hABCD,    32'd1,       32'd2,       32'd2,       0, 0, 0, 0, 0));
        vecs.push_back(mk("nop",   32'h0,        32'd5,       32'd6,       32'h0,       2, 0, 0, 32'd11,      32'd5,       32'd6,       32'd6,       0, 0, 0, 0, 0));
        vecs.push_back(mk("sub_ov",rt_ir(6'h22), 32'h80000000,32'd1,       32'h0,       0, 0, 0, 32'h7FFFFFFF,32'h80000000,32'd1,       32'd1,       1, 0, 0, 0, 0));
        vecs.push_back(mk("addi_o",i_ir(6'h08),  32'h7FFFFFFF,32'h0,       32'd1,       0, 0, 0, 32'h80000000,32'h7FFFFFFF,32'd1,       32'h0,       1, 0, 0, 0, 0));
        vecs.push_back(mk("addiu", i_ir(6'h09),  32'h7FFFFFFF,32'h0,       32'd1,       0, 0, 0, 32'h80000000,32'h7FFFFFFF,32'd1,       32'h0,       0, 0, 0, 0, 0));
        vecs.push_back(mk("multu", rt_ir(6'h19), 32'd1,       32'd1,       32'h0,       0, 0, 0, 32'd2,       32'd1,       32'd1,       32'd1,       0, 0, 1, 1, 0));
        vecs.push_back(mk("div",   rt_ir(6'h1A), 32'd1,       32'd1,       32'h0,       0, 0, 0, 32'd2,       32'd1,       32'd1,       32'd1,       0, 0, 1, 2, 0));
        vecs.push_back(mk("divu",  rt_ir(6'h1B), 32'd9,       32'd2,       32'h0,       0, 0, 0, 32'd11,      32'd9,       32'd2,       32'd2,       0, 0, 1, 3, 0));
        vecs.push_back(mk("mtlo",  rt_ir(6'h13), 32'd1,       32'h0,       32'h0,       0, 0, 0, 32'd1,       32'd1,       32'h0,       32'h0,       0, 0, 0, 0, 2));
        vecs.push_back(mk("sll",   rt_ir(6'h00), 32'h0,       32'd1,       32'h0,       4, 0, 0, 32'h10,      32'h0,       32'd1,       32'd1,       0, 0, 0, 0, 0));
        vecs.push_back(mk("nor",   rt_ir(6'h27), 32'h0,       32'h0,       32'h0,       0, 0, 0, 32'hFFFFFFFF,32'h0,       32'h0,       32'h0,       0, 0, 0, 0, 0));
        vecs.push_back(mk("sw_ov", i_ir(6'h2B),  32'h80000000,32'h77,      32'hFFFFFFFF,0, 0, 0, 32'h7FFFFFFF,32'h80000000,32'hFFFFFFFF,32'h77,      0, 1, 0, 0, 0));
        vecs.push_back(mk("mfhi",  rt_ir(6'h10), 32'd1,       32'd2,       32'h0,       0, 0, 0, 32'h5555,    32'd1,       32'd2,       32'd2,       0, 0, 0, 0, 0));
        vecs.push_back(mk("srav",  rt_ir(6'h07), 32'd8,       32'h80000000,32'h0,       0, 0, 0, 32'hFF800000,32'd8,       32'h80000000,32'h80000000,0, 0, 0, 0, 0));
        vecs.push_back(mk("sltiu", i_ir(6'h0B),  32'd1,       32'h0,       32'hFFFFFFFF,0, 0, 0, 32'd1,       32'd1,       32'hFFFFFFFF,32'h0,       0, 0, 0, 0, 0));
        vecs.push_back(mk("and",   rt_ir(6'h24), 32'hF0F0,    32'hFF00,    32'h0,       0, 0, 0, 32'hF000,    32'hF0F0,    32'hFF00,    32'hFF00,    0, 0, 0, 0, 0));
        vecs.push_back(mk("or",    rt_ir(6'h25), 32'hF0F0,    32'hFF00,    32'h0,       0, 0, 0, 32'hFFF0,    32'hF0F0,    32'hFF00,    32'hFF00,    0, 0, 0, 0, 0));
        vecs.push_back(mk("xor",   rt_ir(6'h26), 32'hF0F0,    32'hFF00,    32'h0,       0, 0, 0, 32'h0FF0,    32'hF0F0,    32'hFF00,    32'hFF00,    0, 0, 0, 0, 0));
        vecs.push_back(mk("andi",  i_ir(6'h0C),  32'hFFFF,    32'h5,       32'h0F0F,    0, 0, 0, 32'h0F0F,    32'hFFFF,    32'h0F0F,    32'h5,       0, 0, 0, 0, 0));

        // Reset with live inputs: E/M must load zeros
        Reset = 1'b1; Flush = 1'b0;
        IRE = rt_ir(6'h21); PC4E = 32'h1234; RSE = 32'd1; RTE = 32'd2; EXTE = 32'h0;
        Shift = 5'd0; Fwd_RS_sel = 2'd0; Fwd_RT_sel = 2'd0;
        @(posedge Clk); #1;
        check_em_zero("reset");

        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            IRE = vecs[i].ir; RSE = vecs[i].rse; RTE = vecs[i].rte; EXTE = vecs[i].exte;
            Shift = vecs[i].sh; Fwd_RS_sel = vecs[i].frs; Fwd_RT_sel = vecs[i].frt;
            PC4E = 32'h3000 + 32'(i * 4);
            #1;
            check({vecs[i].name, ".SrcA"},     SrcA,              vecs[i].srca);
            check({vecs[i].name, ".SrcB"},     SrcB,              vecs[i].srcb);
            check({vecs[i].name, ".OvArith"},  32'(OvArith),      32'(vecs[i].ova));
            check({vecs[i].name, ".OvMem"},    32'(OvMem),        32'(vecs[i].ovm));
            check({vecs[i].name, ".MD_start"}, 32'(MD_start),     32'(vecs[i].mds));
            if (vecs[i].mds)
                check({vecs[i].name, ".MD_op"}, 32'(MD_op),       32'(vecs[i].mdop));
            check({vecs[i].name, ".MD_we"},    32'(MD_we),        32'(vecs[i].mdwe));
            @(posedge Clk); #1;
            check({vecs[i].name, ".AOM"},  AOM,  vecs[i].aom);
            check({vecs[i].name, ".RTM"},  RTM,  vecs[i].rtm);
            check({vecs[i].name, ".IRM"},  IRM,  vecs[i].ir);
            check({vecs[i].name, ".PC4M"}, PC4M, 32'h3000 + 32'(i * 4));
            @(negedge Clk);
        end

        // Flush after a loaded instruction clears E/M, then loading resumes
        IRE = rt_ir(6'h21); RSE = 32'd20; RTE = 32'd22; PC4E = 32'h4000;
        Fwd_RS_sel = 2'd0; Fwd_RT_sel = 2'd0; Shift = 5'd0;
        @(posedge Clk); #1;
        check("preflush.AOM", AOM, 32'd42);
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk); #1;
        check_em_zero("flush");
        @(negedge Clk);
        Flush = 1'b0;
        @(posedge Clk); #1;
        check("postflush.AOM",  AOM,  32'd42);
        check("postflush.PC4M", PC4M, 32'h4000);

        // Reset and Flush together behave like either alone
        @(negedge Clk);
        Reset = 1'b1; Flush = 1'b1;
        @(posedge Clk); #1;
        check_em_zero("rst_flush");
        @(negedge Clk);
        Reset = 1'b0; Flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
